// File: rtl/pc_ir_unit_if.sv
// pc_ir_unit_if -- controller/datapath bundle for the PC / instruction register unit.
//   master : controller-side view (drives control, ALU results and memory word; sees PC/IR state)
//   slave  : the pc_ir_unit itself (samples control/data, drives PC, IR, decodes, counters)
// Signals:
//   IRWrite, PCWrite, PCWriteCond, PCSource[1:0] : control from the multicycle controller
//   alu_result[31:0], zero                       : this cycle's ALU output and zero flag
//   mem_rdata[31:0]                              : word stored at address pc
//   pc, instr, alu_out                           : architectural registers
//   op_in, rs, rt, rd, imm_se, imm_ze, imm_lui   : combinational decodes of instr
//   pc_loaded                                    : one-cycle pulse after a PC update
//   fetch_cnt[CNT_W-1:0]                         : IR loads since reset
interface pc_ir_unit_if #(
    parameter int CNT_W = 16
);
    logic             IRWrite;
    logic             PCWrite;
    logic             PCWriteCond;
    logic [1:0]       PCSource;
    logic [31:0]      alu_result;
    logic             zero;
    logic [31:0]      mem_rdata;

    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [5:0]       op_in;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [31:0]      imm_se;
    logic [31:0]      imm_ze;
    logic [31:0]      imm_lui;
    logic [31:0]      alu_out;
    logic             pc_loaded;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        output IRWrite, PCWrite, PCWriteCond, PCSource, alu_result, zero, mem_rdata,
        input  pc, instr, op_in, rs, rt, rd, imm_se, imm_ze, imm_lui,
               alu_out, pc_loaded, fetch_cnt
    );

    modport slave (
        input  IRWrite, PCWrite, PCWriteCond, PCSource, alu_result, zero, mem_rdata,
        output pc, instr, op_in, rs, rt, rd, imm_se, imm_ze, imm_lui,
               alu_out, pc_loaded, fetch_cnt
    );
endinterface

// File: rtl/pc_ir_unit.sv
// pc_ir_unit -- program counter, instruction register, ALUOut register and
// instruction field decode for a multicycle MIPS-style datapath.
// Ports:
//   clk   : single clock, all state on the rising edge
//   reset : synchronous active-low reset
//   bus   : pc_ir_unit_if.slave (control in, ALU/memory data in, PC/IR state and decodes out)
// Parameters:
//   RESET_PC : PC value after reset
//   CNT_W    : fetch counter width (must match the interface CNT_W)
module pc_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    pc_ir_unit_if.slave  bus
);

    logic             pc_en;
    logic [31:0]      next_pc;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [31:0]      alu_out_q;
    logic             pc_loaded_q;
    logic [CNT_W-1:0] fetch_cnt_q;

    // PCWrite dominates; the conditional write only matters when PCWrite is low.
    assign pc_en = bus.PCWrite | (bus.PCWriteCond & bus.zero);

    // Jump target keeps the upper PC bits of the current (pre-update) PC.
    always_comb begin
        next_pc = pc_q;
        case (bus.PCSource)
            2'b00:   next_pc = bus.alu_result;
            2'b01:   next_pc = alu_out_q;
            2'b10:   next_pc = {pc_q[31:26], instr_q[25:0]};
            default: next_pc = pc_q;
        endcase
    end

    // mem_rdata is addressed by the registered pc, so sampling it here on the
    // same edge that updates pc naturally captures the word at the old pc.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0000_0000;
            alu_out_q   <= 32'h0000_0000;
            pc_loaded_q <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            if (pc_en)
                pc_q <= next_pc;
            if (bus.IRWrite) begin
                instr_q     <= bus.mem_rdata;
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            end
            alu_out_q   <= bus.alu_result;
            pc_loaded_q <= pc_en;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.instr     = instr_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.pc_loaded = pc_loaded_q;
    assign bus.fetch_cnt = fetch_cnt_q;

    // Field decodes straight off the IR, no pipeline stage.
    assign bus.op_in   = instr_q[31:26];
    assign bus.rs      = instr_q[25:21];
    assign bus.rt      = instr_q[20:16];
    assign bus.rd      = instr_q[15:11];
    assign bus.imm_se  = {{16{instr_q[15]}}, instr_q[15:0]};
    assign bus.imm_ze  = {16'h0000, instr_q[15:0]};
    assign bus.imm_lui = {instr_q[15:0], 16'h0000};

endmodule

// File: tb/tb_pc_ir_unit.sv
// tb_pc_ir_unit -- directed plus randomized checks of pc_ir_unit against a
// behavioural model of the PC/IR rules. Memory is a 256-word array indexed by pc[7:0].
module tb_pc_ir_unit;
    localparam int          CNT_W    = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_ir_unit_if #(.CNT_W(CNT_W)) ifc ();

    pc_ir_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    logic [31:0] mem [256];
    assign ifc.mem_rdata = mem[ifc.pc[7:0]];

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_pc, m_instr, m_alu_out;
    logic        m_loaded;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [31:0] lo;
        lo = m_instr & 32'h0000_FFFF;
        chk({tag, ".pc"},        ifc.pc, m_pc);
        chk({tag, ".instr"},     ifc.instr, m_instr);
        chk({tag, ".op_in"},     32'(ifc.op_in), m_instr >> 26);
        chk({tag, ".rs"},        32'(ifc.rs), (m_instr >> 21) % 32);
        chk({tag, ".rt"},        32'(ifc.rt), (m_instr >> 16) % 32);
        chk({tag, ".rd"},        32'(ifc.rd), (m_instr >> 11) % 32);
        chk({tag, ".imm_se"},    ifc.imm_se, (lo >= 32'h8000) ? lo + 32'hFFFF_0000 : lo);
        chk({tag, ".imm_ze"},    ifc.imm_ze, lo);
        chk({tag, ".imm_lui"},   ifc.imm_lui, lo * 32'd65536);
        chk({tag, ".alu_out"},   ifc.alu_out, m_alu_out);
        chk({tag, ".pc_loaded"}, 32'(ifc.pc_loaded), 32'(m_loaded));
        chk({tag, ".fetch_cnt"}, 32'(ifc.fetch_cnt), 32'(m_cnt));
    endtask

    // One clock: drive on the falling edge, advance the model with the
    // pre-edge state, compare shortly after the rising edge.
    task automatic step(input logic rst, input logic irw, input logic pcw, input logic pcc,
                        input logic [1:0] src, input logic [31:0] alu, input logic z,
                        input bit chk_en, input string tag);
        logic [31:0] npc, word;
        bit          en;
        @(negedge clk);
        reset           = rst;
        ifc.IRWrite     = irw;
        ifc.PCWrite     = pcw;
        ifc.PCWriteCond = pcc;
        ifc.PCSource    = src;
        ifc.alu_result  = alu;
        ifc.zero        = z;
        @(posedge clk);
        if (!rst) begin
            m_pc = RESET_PC; m_instr = 0; m_alu_out = 0; m_loaded = 0; m_cnt = 0;
        end else begin
            word = mem[m_pc % 256];
            en   = pcw || (pcc && z);
            case (src)
                2'd0: npc = alu;
                2'd1: npc = m_alu_out;
                2'd2: npc = (m_pc & 32'hFC00_0000) | (m_instr & 32'h03FF_FFFF);
                default: npc = m_pc;
            endcase
            if (irw) begin
                m_instr = word;
                m_cnt   = (m_cnt + 1) % (1 << CNT_W);
            end
            m_alu_out = alu;
            m_loaded  = en;
            if (en) m_pc = npc;
        end
        #1;
        if (chk_en) chk_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[5]     = 32'h8022_0003;
        mem[6]     = 32'h0000_8001;
        mem[8'h10] = 32'h0800_0040;

        // Reset with fetch controls active
        step(0, 1, 1, 0, 2'd0, 32'h1234, 0, 1, "rst0");
        step(0, 1, 1, 1, 2'd1, 32'h5678, 1, 1, "rst1");
        chk("rst.pc", ifc.pc, 32'h0);
        chk("rst.op_in", 32'(ifc.op_in), 32'h0);

        // pc <- 5, then fetch
        step(1, 0, 1, 0, 2'd0, 32'd5, 0, 1, "setpc");
        step(1, 1, 1, 0, 2'd0, 32'd6, 0, 1, "fetch");
        chk("fetch.instr", ifc.instr, 32'h8022_0003);
        chk("fetch.op_in", 32'(ifc.op_in), 32'h20);
        chk("fetch.rs", 32'(ifc.rs), 32'd1);
        chk("fetch.rt", 32'(ifc.rt), 32'd2);
        chk("fetch.imm_se", ifc.imm_se, 32'd3);
        chk("fetch.pc", ifc.pc, 32'd6);
        chk("fetch.cnt", 32'(ifc.fetch_cnt), 32'd1);
        chk("fetch.loaded", 32'(ifc.pc_loaded), 32'd1);

        // Immediate decode from word at pc=6
        step(1, 1, 0, 0, 2'd0, 32'd0, 0, 1, "imm");
        chk("imm.se", ifc.imm_se, 32'hFFFF_8001);
        chk("imm.ze", ifc.imm_ze, 32'h0000_8001);
        chk("imm.lui", ifc.imm_lui, 32'h8001_0000);
        chk("imm.hold_pc", ifc.pc, 32'd6);

        // Branch taken, then not taken
        step(1, 0, 0, 0, 2'd0, 32'h14, 0, 1, "br.calc");
        step(1, 0, 0, 1, 2'd1, 32'h99, 1, 1, "br.taken");
        chk("br.taken.pc", ifc.pc, 32'h14);
        step(1, 0, 0, 1, 2'd1, 32'h77, 0, 1, "br.not");
        chk("br.not.pc", ifc.pc, 32'h14);
        chk("br.not.loaded", 32'(ifc.pc_loaded), 32'd0);
        // PCWrite with PCWriteCond and zero low still loads
        step(1, 0, 1, 1, 2'd1, 32'h0, 0, 1, "br.both");
        chk("br.both.pc", ifc.pc, 32'h77);

        // Jump keeps the upper pc bits
        step(1, 0, 1, 0, 2'd0, 32'hFC00_0010, 0, 1, "j.setpc");
        step(1, 1, 0, 0, 2'd0, 32'h0, 0, 1, "j.ir");
        step(1, 0, 1, 0, 2'd2, 32'h0, 0, 1, "j.go");
        chk("jump.pc", ifc.pc, 32'hFC00_0040);
        // PCSource=11 holds pc but still pulses pc_loaded
        step(1, 0, 1, 0, 2'd3, 32'h5, 0, 1, "hold");
        chk("hold.pc", ifc.pc, 32'hFC00_0040);
        chk("hold.loaded", 32'(ifc.pc_loaded), 32'd1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 2'($urandom), $urandom, 1'($urandom), 1, "rand");

        // Counter wrap: 2^CNT_W + 1 loads from zero
        step(0, 0, 0, 0, 2'd0, 32'h0, 0, 1, "wrap.rst");
        for (int i = 0; i < (1 << CNT_W) + 1; i++)
            step(1, 1, 0, 0, 2'd0, 32'(i), 0, 0, "wrap");
        chk_all("wrap.end");
        chk("wrap.cnt", 32'(ifc.fetch_cnt), 32'd1);
        step(1, 0, 1, 0, 2'd0, 32'hABCD_0000, 0, 1, "pre");
        step(0, 1, 1, 0, 2'd0, 32'h1111_2222, 0, 1, "rst.mid");
        chk("rst.mid.pc", ifc.pc, RESET_PC);
        chk("rst.mid.instr", ifc.instr, 32'h0);
        chk("rst.mid.cnt", 32'(ifc.fetch_cnt), 32'd0);
        // First edge out of reset acts normally
        step(1, 1, 1, 0, 2'd0, 32'h0000_0042, 0, 1, "post");
        chk("post.pc", ifc.pc, 32'h42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
